// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and sizing helpers for the fft acquisition sequencer
package fft_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FLUSH,
        WAIT_BUF,
        START,
        LOAD,
        DRAIN,
        NEXT,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_FFT     = 2'd1,
        ERR_FRAMING = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    function automatic int fft_length(input int depth);
        return 1 << depth;
    endfunction

    function automatic int default_timeout(input int depth);
        return 4 * fft_length(depth);
    endfunction

endpackage

// File: rtl/frame_checker.sv
// rtl/frame_checker.sv - beat counter and sop/eop framing check for frames entering the fft sink
module frame_checker
    import fft_pkg::*;
#(
    parameter int FFT_DEPTH = 11
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    input  logic in_valid,
    input  logic in_sop,
    input  logic in_eop,
    output logic framing_err,
    output logic frame_end
);

    localparam int                 FRAME_LEN = fft_length(FFT_DEPTH);
    localparam logic [FFT_DEPTH:0] LAST_BEAT = (FFT_DEPTH + 1)'(FRAME_LEN - 1);

    logic [FFT_DEPTH:0] beat;
    logic               first_beat;
    logic               last_beat;
    logic               sop_bad;
    logic               eop_bad;
    logic               beat_taken;

    // Strobes only count on accepted beats; idle-cycle sop/eop are noise
    assign beat_taken = enable && in_valid;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            beat <= '0;
        end else if (beat_taken) begin
            beat <= beat + 1'b1;
        end
    end

    assign first_beat  = (beat == '0);
    assign last_beat   = (beat == LAST_BEAT);
    assign sop_bad     = (in_sop != first_beat);
    assign eop_bad     = (in_eop != last_beat);
    assign framing_err = beat_taken && (sop_bad || eop_bad);
    assign frame_end   = beat_taken && in_eop && last_beat && !sop_bad;

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - acquisition sequencer releasing RUNS frames through a streaming fft core
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int FFT_DEPTH = 11,
    parameter int RUNS      = 3,
    parameter int TIMEOUT   = default_timeout(FFT_DEPTH)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       buf_ready,
    output logic       buf_start,
    input  logic       in_sop,
    input  logic       in_eop,
    input  logic       in_valid,
    input  logic       out_sop,
    input  logic       out_eop,
    input  logic       out_valid,
    input  logic       fft_error,
    output logic       fft_aclr,
    output logic       busy,
    output logic       frame_done,
    output logic       done,
    output logic [7:0] run_idx,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int            TW           = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    RUNS_LAST    = 8'(RUNS - 1);

    state_t        state;
    state_t        state_next;
    err_code_t     err_cause;
    logic          flush_cnt;
    logic          flush_to_idle;
    logic          flush_restart;
    logic [TW-1:0] drain_cnt;
    logic          fire_start;
    logic          fire_next;
    logic          fire_done;
    logic          framing_err;
    logic          frame_end;
    logic          unused_out_sop;

    assign unused_out_sop = out_sop;

    frame_checker #(
        .FFT_DEPTH(FFT_DEPTH)
    ) u_frame_checker (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (state == START),
        .enable     (state == LOAD),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .framing_err(framing_err),
        .frame_end  (frame_end)
    );

    always_comb begin
        state_next = state;
        err_cause  = ERR_NONE;
        case (state)
            IDLE:     if (start && !abort) state_next = FLUSH;
            FLUSH:    if (flush_cnt) state_next = flush_to_idle ? IDLE : WAIT_BUF;
            WAIT_BUF: if (buf_ready) state_next = START;
            START:    state_next = LOAD;
            LOAD: begin
                if (framing_err) begin
                    state_next = ERROR;
                    err_cause  = ERR_FRAMING;
                end else if (frame_end) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_eop) begin
                    state_next = NEXT;
                end else if (drain_cnt == TIMEOUT_LAST) begin
                    state_next = ERROR;
                    err_cause  = ERR_TIMEOUT;
                end
            end
            NEXT:     state_next = (run_idx == RUNS_LAST) ? DONE : WAIT_BUF;
            DONE:     state_next = IDLE;
            ERROR:    state_next = FLUSH;
            default:  state_next = IDLE;
        endcase

        // fft_error outranks framing/timeout; abort outranks everything
        if (fft_error && (state inside {WAIT_BUF, START, LOAD, DRAIN, NEXT, DONE})) begin
            state_next = ERROR;
            err_cause  = ERR_FFT;
        end
        if (abort && state != IDLE) begin
            state_next = FLUSH;
            err_cause  = ERR_NONE;
        end
    end

    assign flush_restart = (state_next == FLUSH) && ((state != FLUSH) || abort);
    assign fire_start    = (state == START) && (state_next == LOAD);
    assign fire_next     = (state == NEXT) && (state_next inside {DONE, WAIT_BUF});
    assign fire_done     = (state == DONE) && (state_next == IDLE);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            flush_cnt     <= 1'b0;
            flush_to_idle <= 1'b0;
            drain_cnt     <= '0;
            buf_start     <= 1'b0;
            fft_aclr      <= 1'b1;
            frame_done    <= 1'b0;
            done          <= 1'b0;
            run_idx       <= 8'd0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            state      <= state_next;
            buf_start  <= fire_start;
            frame_done <= fire_next;
            done       <= fire_done;
            fft_aclr   <= (state_next == FLUSH);
            drain_cnt  <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

            // Flushes entered from anywhere but IDLE are clean-up flushes
            if (flush_restart) begin
                flush_cnt     <= 1'b0;
                flush_to_idle <= (state != IDLE);
            end else if (state == FLUSH) begin
                flush_cnt <= 1'b1;
            end

            if (state == IDLE && state_next == FLUSH) begin
                run_idx  <= 8'd0;
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
            if (fire_next) begin
                run_idx <= run_idx + 1'b1;
            end
            if (state_next == ERROR && state != ERROR) begin
                err <= 1'b1;
                if (!err) begin
                    err_code <= err_cause;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - self-checking bench for fft_sequencer with a transaction-level outcome model
module tb_fft_sequencer;

    localparam int FFT_DEPTH = 3;
    localparam int RUNS      = 3;
    localparam int TIMEOUT   = 32;
    localparam int FLEN      = 1 << FFT_DEPTH;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       buf_ready = 1'b0;
    logic       in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
    logic       out_sop = 1'b0, out_eop = 1'b0, out_valid = 1'b0;
    logic       fft_error = 1'b0;
    logic       buf_start, fft_aclr, busy, frame_done, done, err;
    logic [7:0] run_idx;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int n_fd    = 0;
    int n_done  = 0;

    fft_sequencer #(
        .FFT_DEPTH(FFT_DEPTH),
        .RUNS     (RUNS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .buf_ready (buf_ready),
        .buf_start (buf_start),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_valid  (in_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_valid (out_valid),
        .fft_error (fft_error),
        .fft_aclr  (fft_aclr),
        .busy      (busy),
        .frame_done(frame_done),
        .done      (done),
        .run_idx   (run_idx),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_fd++;
        if (done) n_done++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_buf_start(output bit ok);
        int k;
        ok = 1'b0;
        tick($urandom_range(0, 3));
        buf_ready = 1'b1;
        for (k = 0; k < 30 && !ok; k++) begin
            tick();
            if (buf_start) ok = 1'b1;
        end
        buf_ready = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_buf_start: no buf_start within 30 cycles");
        end
    endtask

    task automatic wait_idle(input int bound);
        int k;
        for (k = 0; k < bound && busy; k++) tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b still after %0d cycles, expected 0", busy, bound);
        end
    endtask

    // Beats 0..FLEN-1 with random idle gaps carrying stray strobes
    task automatic send_frame(input int bad_beat, input bit bad_sop, input int ferr_beat);
        int g;
        for (int b = 0; b < FLEN; b++) begin
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_sop   = 1'($urandom_range(0, 1));
                in_eop   = 1'($urandom_range(0, 1));
                tick();
            end
            in_valid  = 1'b1;
            in_sop    = (b == 0);
            in_eop    = (b == FLEN - 1);
            if (b == bad_beat) begin
                if (bad_sop) in_sop = 1'b1;
                else in_eop = 1'b1;
            end
            fft_error = (b == ferr_beat);
            tick();
            if (b == bad_beat || b == ferr_beat) break;
        end
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        fft_error = 1'b0;
    endtask

    task automatic drain(input int d);
        int r;
        repeat (d) begin
            r = $urandom_range(0, 3);
            out_valid = (r == 1);
            out_eop   = (r == 2);
            tick();
        end
        out_valid = 1'b1;
        out_eop   = 1'b1;
        tick();
        out_valid = 1'b0;
        out_eop   = 1'b0;
    endtask

    task automatic run_frames(input int n);
        bit ok;
        for (int f = 0; f < n; f++) begin
            wait_buf_start(ok);
            if (!ok) break;
            send_frame(-1, 1'b0, -1);
            drain($urandom_range(0, 25));
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        n_tests++;
        if ({buf_start, fft_aclr, busy, frame_done, done, err} !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_flags: {bs,aclr,busy,fd,done,err}=%b expected 010000",
                     {buf_start, fft_aclr, busy, frame_done, done, err});
        end
        n_tests++;
        if (run_idx !== 8'd0 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_counts: run_idx=%0d err_code=%0d expected 0/0", run_idx, err_code);
        end
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (fft_aclr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_aclr: fft_aclr=%b expected 0", fft_aclr);
        end
    endtask

    task automatic test_clean();
        int k, fd0, dn0;
        bit ok;
        fd0 = n_fd;
        dn0 = n_done;
        buf_ready = 1'b1;
        pulse_start();
        k = 1;
        n_tests++;
        if (fft_aclr !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_flush1: aclr=%b busy=%b expected 1/1", fft_aclr, busy);
        end
        tick();
        k = 2;
        n_tests++;
        if (fft_aclr !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_flush2: aclr=%b expected 1", fft_aclr);
        end
        tick();
        k = 3;
        n_tests++;
        if (fft_aclr !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_flush_end: aclr=%b expected 0", fft_aclr);
        end
        while (!buf_start && k < 20) begin
            tick();
            k++;
        end
        buf_ready = 1'b0;
        n_tests++;
        if (k !== 5) begin
            n_fail++;
            $display("FAIL clean_latency: buf_start after %0d cycles, expected 5", k);
        end
        for (int f = 0; f < RUNS; f++) begin
            if (f > 0) begin
                wait_buf_start(ok);
                if (!ok) break;
            end
            send_frame(-1, 1'b0, -1);
            if (f == 1) begin
                pulse_start();
                drain(19);
            end else begin
                drain(20);
            end
        end
        wait_idle(40);
        tick(2);
        n_tests++;
        if (n_fd - fd0 !== RUNS || n_done - dn0 !== 1) begin
            n_fail++;
            $display("FAIL clean_pulses: frame_done=%0d done=%0d expected %0d/1", n_fd - fd0, n_done - dn0, RUNS);
        end
        n_tests++;
        if (run_idx !== 8'(RUNS) || err !== 1'b0 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL clean_final: run_idx=%0d err=%b code=%0d expected %0d/0/0", run_idx, err, err_code, RUNS);
        end
    endtask

    task automatic test_framing();
        int dn0;
        bit ok;
        dn0 = n_done;
        pulse_start();
        wait_buf_start(ok);
        send_frame(5, 1'b0, -1);
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL framing_code: err=%b code=%0d expected 1/2", err, err_code);
        end
        tick();
        n_tests++;
        if (fft_aclr !== 1'b1) begin
            n_fail++;
            $display("FAIL framing_aclr1: aclr=%b expected 1", fft_aclr);
        end
        tick();
        n_tests++;
        if (fft_aclr !== 1'b1) begin
            n_fail++;
            $display("FAIL framing_aclr2: aclr=%b expected 1", fft_aclr);
        end
        tick();
        n_tests++;
        if (fft_aclr !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_idle: aclr=%b busy=%b expected 0/0", fft_aclr, busy);
        end
        tick(2);
        n_tests++;
        if (n_done - dn0 !== 0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL framing_nodone: done=%0d err=%b expected 0/1", n_done - dn0, err);
        end
    endtask

    task automatic test_timeout();
        int k;
        bit ok;
        pulse_start();
        wait_buf_start(ok);
        send_frame(-1, 1'b0, -1);
        k = 1;
        while (!err && k < 60) begin
            tick();
            k++;
        end
        n_tests++;
        if (k - 1 !== TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_cycles: %0d drain cycles before error, expected %0d", k - 1, TIMEOUT);
        end
        n_tests++;
        if (err_code !== 2'd3) begin
            n_fail++;
            $display("FAIL timeout_code: code=%0d expected 3", err_code);
        end
        wait_idle(20);
    endtask

    task automatic test_priority();
        bit ok;
        pulse_start();
        wait_buf_start(ok);
        send_frame(5, 1'b0, 5);
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'd1) begin
            n_fail++;
            $display("FAIL priority_code: err=%b code=%0d expected 1/1", err, err_code);
        end
        wait_idle(20);
    endtask

    task automatic test_abort();
        int fd0, dn0;
        bit ok;
        fd0 = n_fd;
        dn0 = n_done;
        pulse_start();
        wait_buf_start(ok);
        send_frame(-1, 1'b0, -1);
        drain(5);
        wait_buf_start(ok);
        send_frame(-1, 1'b0, -1);
        tick(3);
        abort     = 1'b1;
        out_valid = 1'b1;
        out_eop   = 1'b1;
        tick();
        abort     = 1'b0;
        out_valid = 1'b0;
        out_eop   = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || fft_aclr !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_flush1: busy=%b aclr=%b expected 1/1", busy, fft_aclr);
        end
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_flush2: busy=%b expected 1", busy);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b expected 0 three cycles after abort", busy);
        end
        tick(2);
        n_tests++;
        if (n_fd - fd0 !== 1 || n_done - dn0 !== 0 || run_idx !== 8'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_result: fd=%0d done=%0d run_idx=%0d err=%b expected 1/0/1/0",
                     n_fd - fd0, n_done - dn0, run_idx, err);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_over_start: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int fd0, dn0;
        bit ok;
        pulse_start();
        wait_buf_start(ok);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_sop   = (b == 0);
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        dn0      = n_done;
        reset_n  = 1'b0;
        tick();
        n_tests++;
        if ({buf_start, fft_aclr, busy, frame_done, done, err} !== 6'b010000 ||
            run_idx !== 8'd0 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: {bs,aclr,busy,fd,done,err}=%b run_idx=%0d code=%0d expected 010000/0/0",
                     {buf_start, fft_aclr, busy, frame_done, done, err}, run_idx, err_code);
        end
        reset_n = 1'b1;
        tick(2);
        fd0 = n_fd;
        n_tests++;
        if (n_done - dn0 !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_nodone: done=%0d expected 0", n_done - dn0);
        end
        dn0 = n_done;
        pulse_start();
        run_frames(RUNS);
        wait_idle(40);
        tick(2);
        n_tests++;
        if (n_fd - fd0 !== RUNS || n_done - dn0 !== 1 || run_idx !== 8'(RUNS) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: fd=%0d done=%0d run_idx=%0d err=%b expected %0d/1/%0d/0",
                     n_fd - fd0, n_done - dn0, run_idx, err, RUNS, RUNS);
        end
    endtask

    // Outcome model: frames complete in order until the first injected fault
    task automatic test_random();
        int fault_frame, fault_kind, bad_beat, fd0, dn0, exp_runs, exp_code;
        bit hit, bad_sop, ok;
        for (int it = 0; it < 15; it++) begin
            fault_frame = $urandom_range(0, RUNS + 1);
            fault_kind  = $urandom_range(1, 3);
            fd0 = n_fd;
            dn0 = n_done;
            exp_runs = 0;
            exp_code = 0;
            hit = 1'b0;
            pulse_start();
            for (int f = 0; f < RUNS && !hit; f++) begin
                wait_buf_start(ok);
                if (!ok) break;
                if (f == fault_frame && fault_kind == 1) begin
                    send_frame(-1, 1'b0, $urandom_range(0, FLEN - 1));
                    hit = 1'b1;
                    exp_code = 1;
                end else if (f == fault_frame && fault_kind == 2) begin
                    bad_sop  = 1'($urandom_range(0, 1));
                    bad_beat = bad_sop ? int'($urandom_range(1, FLEN - 1)) : int'($urandom_range(0, FLEN - 2));
                    send_frame(bad_beat, bad_sop, -1);
                    hit = 1'b1;
                    exp_code = 2;
                end else begin
                    send_frame(-1, 1'b0, -1);
                    if (f == fault_frame) begin
                        hit = 1'b1;
                        exp_code = 3;
                    end else begin
                        drain($urandom_range(0, 25));
                        exp_runs++;
                    end
                end
            end
            wait_idle(100);
            tick(2);
            n_tests++;
            if (run_idx !== 8'(exp_runs) || n_fd - fd0 !== exp_runs) begin
                n_fail++;
                $display("FAIL random_runs[%0d]: run_idx=%0d frame_done=%0d expected %0d",
                         it, run_idx, n_fd - fd0, exp_runs);
            end
            n_tests++;
            if (err !== hit || err_code !== 2'(exp_code)) begin
                n_fail++;
                $display("FAIL random_err[%0d]: err=%b code=%0d expected %b/%0d", it, err, err_code, hit, exp_code);
            end
            n_tests++;
            if (n_done - dn0 !== (hit ? 0 : 1)) begin
                n_fail++;
                $display("FAIL random_done[%0d]: done=%0d expected %0d", it, n_done - dn0, hit ? 0 : 1);
            end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_clean();
        test_framing();
        test_timeout();
        test_priority();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
